// File: rtl/exc_commit_unit_pkg.sv
// Shared types and constants for the exception commit unit: pipeline exception
// flags, MIPS ExcCodes, CP0 register addresses and the redirect FSM state.
package exc_commit_unit_pkg;

  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic ReservedInstruction;
    logic Overflow;
    logic Trap;
    logic Syscall;
    logic Break;
    logic RdWrongAddressinMEM;
    logic WrWrongAddressinMEM;
    logic TLBRefill;
    logic TLBInvalid;
    logic TLBModified;
    logic Eret;
    logic Refetch;
  } ExceptinPipeType;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_MOD  = 5'h01;
  localparam logic [4:0] EXC_TLBL = 5'h02;
  localparam logic [4:0] EXC_TLBS = 5'h03;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_TR   = 5'h0D;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    BADV_NONE = 2'd0,
    BADV_PC   = 2'd1,
    BADV_DATA = 2'd2
  } badv_sel_e;

endpackage

// File: rtl/exc_commit_unit_prio.sv
// Combinational priority encoder: collapses the pending exception flags into a
// single action. TLB causes are decoded only when EXC_TLB_EN is defined.
module exc_prio_encoder
  import exc_commit_unit_pkg::*;
(
  input  ExceptinPipeType flags,
  input  logic            exl,
  output logic            take,
  output logic            is_eret,
  output logic            is_refetch,
  output logic [4:0]      excode,
  output badv_sel_e       badvaddr_sel,
  output logic            use_refill
);

  // NOTE: every output gets a default before the if-chain so no path can infer a latch.
  // An X flag evaluates false in an if, so unknown flags fall through to "no action".
  always_comb begin
    take         = 1'b0;
    is_eret      = 1'b0;
    is_refetch   = 1'b0;
    excode       = EXC_INT;
    badvaddr_sel = BADV_NONE;
    use_refill   = 1'b0;
    if (flags.Interrupt && !exl) begin
      take = 1'b1;
    end else if (flags.WrongAddressinIF) begin
      take = 1'b1; excode = EXC_ADEL; badvaddr_sel = BADV_PC;
    end else if (flags.ReservedInstruction) begin
      take = 1'b1; excode = EXC_RI;
    end else if (flags.Overflow) begin
      take = 1'b1; excode = EXC_OV;
    end else if (flags.Trap) begin
      take = 1'b1; excode = EXC_TR;
    end else if (flags.Syscall) begin
      take = 1'b1; excode = EXC_SYS;
    end else if (flags.Break) begin
      take = 1'b1; excode = EXC_BP;
    end else if (flags.RdWrongAddressinMEM) begin
      take = 1'b1; excode = EXC_ADEL; badvaddr_sel = BADV_DATA;
    end else if (flags.WrWrongAddressinMEM) begin
      take = 1'b1; excode = EXC_ADES; badvaddr_sel = BADV_DATA;
`ifdef EXC_TLB_EN
    end else if (flags.TLBRefill) begin
      take = 1'b1; badvaddr_sel = BADV_DATA; use_refill = !exl;
      excode = flags.WrWrongAddressinMEM ? EXC_TLBS : EXC_TLBL;
    end else if (flags.TLBInvalid) begin
      take = 1'b1; badvaddr_sel = BADV_DATA;
      excode = flags.WrWrongAddressinMEM ? EXC_TLBS : EXC_TLBL;
    end else if (flags.TLBModified) begin
      take = 1'b1; excode = EXC_MOD; badvaddr_sel = BADV_DATA;
`endif
    end else if (flags.Eret) begin
      is_eret = 1'b1;
    end else if (flags.Refetch) begin
      is_refetch = 1'b1;
    end
  end

`ifndef EXC_TLB_EN
  // TLB flags are deliberately left unconnected in this build.
  logic unused_tlb;
  assign unused_tlb = ^{flags.TLBRefill, flags.TLBInvalid, flags.TLBModified};
`endif

endmodule

// File: rtl/exc_commit_unit.sv
// Exception commit unit: prioritises committing exceptions, updates EPC/Cause/
// Status/BadVAddr and redirects IF via valid/ready. Optional TLB causes: EXC_TLB_EN.
module exc_commit_unit
  import exc_commit_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
  parameter logic [31:0] REFILL_VECTOR = 32'hBFC0_0200
) (
  input  logic            clk,
  input  logic            rst,
  input  ExceptinPipeType MEM_ExceptType,
  input  logic            MEM_Valid,
  input  logic            MEM_Stall,
  input  logic [31:0]     MEM_PC,
  input  logic            MEM_IsInDelaySlot,
  input  logic [31:0]     MEM_DataAddr,
  input  logic            CP0_We,
  input  logic [4:0]      CP0_Waddr,
  input  logic [31:0]     CP0_Wdata,
  output logic            Flush,
  output logic            Redirect_Valid,
  input  logic            Redirect_Ready,
  output logic [31:0]     Redirect_PC,
  output logic [31:0]     EPC_o,
  output logic [4:0]      Cause_ExcCode_o,
  output logic            Cause_BD_o,
  output logic            Status_EXL_o,
  output logic [31:0]     BadVAddr_o
);

  state_e      state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  excode_q, excode_d;
  logic        bd_q, bd_d;
  logic        exl_q, exl_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        pe_take, pe_eret, pe_refetch, pe_refill;
  logic [4:0]  pe_excode;
  badv_sel_e   pe_badv_sel;
  logic        commit, redirect_evt;

  exc_prio_encoder u_prio (
    .flags        (MEM_ExceptType),
    .exl          (exl_q),
    .take         (pe_take),
    .is_eret      (pe_eret),
    .is_refetch   (pe_refetch),
    .excode       (pe_excode),
    .badvaddr_sel (pe_badv_sel),
    .use_refill   (pe_refill)
  );

  assign commit       = MEM_Valid && !MEM_Stall && (state_q == ST_NORMAL);
  assign redirect_evt = commit && (pe_take || pe_eret || pe_refetch);

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    epc_d         = epc_q;
    excode_d      = excode_q;
    bd_d          = bd_q;
    exl_d         = exl_q;
    badvaddr_d    = badvaddr_q;

    case (state_q)
      ST_NORMAL: begin
        if (redirect_evt) begin
          state_d = ST_REDIRECT;
          if (pe_take) begin
            excode_d = pe_excode;
            // Nested exceptions keep the EPC/BD of the outermost handler.
            if (!exl_q) begin
              epc_d = MEM_IsInDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
              bd_d  = MEM_IsInDelaySlot;
            end
            exl_d         = 1'b1;
            redirect_pc_d = pe_refill ? REFILL_VECTOR : EXC_VECTOR;
            if (pe_badv_sel == BADV_PC)   badvaddr_d = MEM_PC;
            if (pe_badv_sel == BADV_DATA) badvaddr_d = MEM_DataAddr;
          end else if (pe_eret) begin
            exl_d         = 1'b0;
            redirect_pc_d = epc_q;
          end else begin
            redirect_pc_d = MEM_PC;
          end
        end
      end
      ST_REDIRECT: begin
        if (Redirect_Ready) state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase

    // A committing redirect event takes precedence over a same-cycle MTC0.
    if (CP0_We && !redirect_evt) begin
      case (CP0_Waddr)
        CP0_BADVADDR: badvaddr_d = CP0_Wdata;
        CP0_STATUS:   exl_d      = CP0_Wdata[1];
        CP0_CAUSE:    excode_d   = CP0_Wdata[6:2];
        CP0_EPC:      epc_d      = CP0_Wdata;
        default:      ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_NORMAL;
      redirect_pc_q <= '0;
      epc_q         <= '0;
      excode_q      <= '0;
      bd_q          <= 1'b0;
      exl_q         <= 1'b0;
      badvaddr_q    <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      epc_q         <= epc_d;
      excode_q      <= excode_d;
      bd_q          <= bd_d;
      exl_q         <= exl_d;
      badvaddr_q    <= badvaddr_d;
    end
  end

  assign Flush           = (state_q == ST_REDIRECT);
  assign Redirect_Valid  = (state_q == ST_REDIRECT);
  assign Redirect_PC     = redirect_pc_q;
  assign EPC_o           = epc_q;
  assign Cause_ExcCode_o = excode_q;
  assign Cause_BD_o      = bd_q;
  assign Status_EXL_o    = exl_q;
  assign BadVAddr_o      = badvaddr_q;

endmodule

// File: tb/tb_exc_commit_unit.sv
// Scoreboard bench for exc_commit_unit: directed commits push expected CP0/redirect
// state; a negedge monitor compares on each new Redirect_Valid.
module tb_exc_commit_unit;
  import exc_commit_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  ExceptinPipeType MEM_ExceptType;
  logic            MEM_Valid, MEM_Stall, MEM_IsInDelaySlot;
  logic [31:0]     MEM_PC, MEM_DataAddr;
  logic            CP0_We;
  logic [4:0]      CP0_Waddr;
  logic [31:0]     CP0_Wdata;
  logic            Flush, Redirect_Valid, Redirect_Ready;
  logic [31:0]     Redirect_PC, EPC_o, BadVAddr_o;
  logic [4:0]      Cause_ExcCode_o;
  logic            Cause_BD_o, Status_EXL_o;

  exc_commit_unit dut (
    .clk               (clk),
    .rst               (rst),
    .MEM_ExceptType    (MEM_ExceptType),
    .MEM_Valid         (MEM_Valid),
    .MEM_Stall         (MEM_Stall),
    .MEM_PC            (MEM_PC),
    .MEM_IsInDelaySlot (MEM_IsInDelaySlot),
    .MEM_DataAddr      (MEM_DataAddr),
    .CP0_We            (CP0_We),
    .CP0_Waddr         (CP0_Waddr),
    .CP0_Wdata         (CP0_Wdata),
    .Flush             (Flush),
    .Redirect_Valid    (Redirect_Valid),
    .Redirect_Ready    (Redirect_Ready),
    .Redirect_PC       (Redirect_PC),
    .EPC_o             (EPC_o),
    .Cause_ExcCode_o   (Cause_ExcCode_o),
    .Cause_BD_o        (Cause_BD_o),
    .Status_EXL_o      (Status_EXL_o),
    .BadVAddr_o        (BadVAddr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] epc;
    logic [4:0]  code;
    logic        bd;
    logic        exl;
    logic [31:0] badv;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Monitor: each fresh redirect must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && Redirect_Valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_redirect", {31'd0, Redirect_Valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("redirect_pc", Redirect_PC, e.rpc);
        check("epc", EPC_o, e.epc);
        check("exccode", {27'd0, Cause_ExcCode_o}, {27'd0, e.code});
        check("bd", {31'd0, Cause_BD_o}, {31'd0, e.bd});
        check("exl", {31'd0, Status_EXL_o}, {31'd0, e.exl});
        check("badvaddr", BadVAddr_o, e.badv);
        check("flush_with_valid", {31'd0, Flush}, 32'd1);
      end
    end
    prev_valid = Redirect_Valid;
  end

  function automatic ExceptinPipeType fl(input string which);
    ExceptinPipeType f;
    f = '0;
    case (which)
      "int":  f.Interrupt = 1'b1;
      "ov":   f.Overflow = 1'b1;
      "sys":  f.Syscall = 1'b1;
      "bp":   f.Break = 1'b1;
      "adel": f.RdWrongAddressinMEM = 1'b1;
      "adel_ov": begin f.RdWrongAddressinMEM = 1'b1; f.Overflow = 1'b1; end
      "eret": f.Eret = 1'b1;
      "refetch": f.Refetch = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  function automatic exp_t mk(input logic [31:0] rpc, input logic [31:0] epc, input logic [4:0] code,
                              input logic bd, input logic exl, input logic [31:0] badv);
    exp_t e;
    e.rpc = rpc; e.epc = epc; e.code = code; e.bd = bd; e.exl = exl; e.badv = badv;
    return e;
  endfunction

  task automatic drive_commit(input ExceptinPipeType f, input logic [31:0] pc, input logic ds,
                              input logic [31:0] daddr);
    MEM_ExceptType = f; MEM_PC = pc; MEM_IsInDelaySlot = ds; MEM_DataAddr = daddr;
    MEM_Valid = 1'b1;
    @(posedge clk); #1;
    MEM_Valid = 1'b0; MEM_ExceptType = '0; MEM_IsInDelaySlot = 1'b0;
  endtask

  task automatic commit_evt(input ExceptinPipeType f, input logic [31:0] pc, input logic ds,
                            input logic [31:0] daddr, input exp_t e);
    exp_q.push_back(e);
    drive_commit(f, pc, ds, daddr);
  endtask

  task automatic cp0_write(input logic [4:0] addr, input logic [31:0] data);
    CP0_We = 1'b1; CP0_Waddr = addr; CP0_Wdata = data;
    @(posedge clk); #1;
    CP0_We = 1'b0;
  endtask

  task automatic wait_idle();
    int seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!Redirect_Valid) begin
        seen = 1;
        break;
      end
    end
    if (seen == 0) check("redirect_timeout", {31'd0, Redirect_Valid}, 32'd0);
    check("scoreboard_drain", exp_q.size(), 32'd0);
  endtask

  localparam logic [31:0] EV = 32'hBFC0_0380;

  initial begin
    int cnt;
    rst = 1'b1; MEM_ExceptType = '0; MEM_Valid = 1'b0; MEM_Stall = 1'b0;
    MEM_PC = '0; MEM_IsInDelaySlot = 1'b0; MEM_DataAddr = '0;
    CP0_We = 1'b0; CP0_Waddr = '0; CP0_Wdata = '0; Redirect_Ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_flush", {31'd0, Flush}, 32'd0);
    check("rst_valid", {31'd0, Redirect_Valid}, 32'd0);
    check("rst_rpc", Redirect_PC, 32'd0);
    check("rst_epc", EPC_o, 32'd0);
    check("rst_exl", {31'd0, Status_EXL_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Overflow, EXL=0, not in delay slot.
    commit_evt(fl("ov"), 32'h8000_1000, 1'b0, 32'h0,
               mk(EV, 32'h8000_1000, EXC_OV, 1'b0, 1'b1, 32'h0));
    wait_idle();

    // Syscall in delay slot: EPC points at the branch.
    cp0_write(CP0_STATUS, 32'h0);
    check("mtc0_status_clear", {31'd0, Status_EXL_o}, 32'd0);
    commit_evt(fl("sys"), 32'h8000_2004, 1'b1, 32'h0,
               mk(EV, 32'h8000_2000, EXC_SYS, 1'b1, 1'b1, 32'h0));
    wait_idle();

    // Overflow outranks the load address error; BadVAddr untouched.
    cp0_write(CP0_STATUS, 32'h0);
    commit_evt(fl("adel_ov"), 32'h8000_4000, 1'b0, 32'h8000_0003,
               mk(EV, 32'h8000_4000, EXC_OV, 1'b0, 1'b1, 32'h0));
    wait_idle();
    cp0_write(CP0_STATUS, 32'h0);
    commit_evt(fl("adel"), 32'h8000_4010, 1'b0, 32'h8000_0003,
               mk(EV, 32'h8000_4010, EXC_ADEL, 1'b0, 1'b1, 32'h8000_0003));
    wait_idle();

    // Nested Break with EXL=1 keeps EPC; Eret then returns to it.
    cp0_write(CP0_EPC, 32'h8000_1000);
    check("mtc0_epc", EPC_o, 32'h8000_1000);
    commit_evt(fl("bp"), 32'h8000_3000, 1'b0, 32'h0,
               mk(EV, 32'h8000_1000, EXC_BP, 1'b0, 1'b1, 32'h8000_0003));
    wait_idle();
    commit_evt(fl("eret"), 32'h8000_3004, 1'b0, 32'h0,
               mk(32'h8000_1000, 32'h8000_1000, EXC_BP, 1'b0, 1'b0, 32'h8000_0003));
    wait_idle();

    // Ready held low for three edges: four flush cycles, Overflow ignored meanwhile.
    Redirect_Ready = 1'b0;
    commit_evt(fl("ov"), 32'h8000_5000, 1'b0, 32'h0,
               mk(EV, 32'h8000_5000, EXC_OV, 1'b0, 1'b1, 32'h8000_0003));
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(Flush && Redirect_Valid)) break;
      cnt++;
      if (cnt == 1) begin
        MEM_Valid = 1'b1; MEM_ExceptType = fl("ov"); MEM_PC = 32'h8000_6000;
      end
      if (cnt == 4) begin
        MEM_Valid = 1'b0; MEM_ExceptType = '0; Redirect_Ready = 1'b1;
      end
    end
    check("flush_len", cnt, 32'd4);
    check("ignored_ov_epc", EPC_o, 32'h8000_5000);
    check("scoreboard_drain", exp_q.size(), 32'd0);
    @(negedge clk);
    check("no_extra_flush", {31'd0, Flush}, 32'd0);

    // Reset asserted in the middle of a redirect clears everything at once.
    Redirect_Ready = 1'b0;
    commit_evt(fl("sys"), 32'h8000_7000, 1'b0, 32'h0,
               mk(EV, 32'h8000_5000, EXC_SYS, 1'b0, 1'b1, 32'h8000_0003));
    @(negedge clk); #2;
    rst = 1'b1; #1;
    check("midrst_flush", {31'd0, Flush}, 32'd0);
    check("midrst_valid", {31'd0, Redirect_Valid}, 32'd0);
    check("midrst_rpc", Redirect_PC, 32'd0);
    check("midrst_epc", EPC_o, 32'd0);
    check("midrst_code", {27'd0, Cause_ExcCode_o}, 32'd0);
    check("midrst_bd", {31'd0, Cause_BD_o}, 32'd0);
    check("midrst_exl", {31'd0, Status_EXL_o}, 32'd0);
    check("midrst_badv", BadVAddr_o, 32'd0);
    check("scoreboard_drain", exp_q.size(), 32'd0);
    @(negedge clk);
    rst = 1'b0; Redirect_Ready = 1'b1;
    @(posedge clk); #1;

    // Interrupt while EXL=1 is masked.
    cp0_write(CP0_STATUS, 32'h2);
    check("mtc0_status_set", {31'd0, Status_EXL_o}, 32'd1);
    drive_commit(fl("int"), 32'h8000_8000, 1'b0, 32'h0);
    @(negedge clk);
    check("masked_int_flush", {31'd0, Flush}, 32'd0);

    // Syscall beats a same-cycle MTC0 to EPC.
    cp0_write(CP0_STATUS, 32'h0);
    CP0_We = 1'b1; CP0_Waddr = CP0_EPC; CP0_Wdata = 32'h0000_1234;
    commit_evt(fl("sys"), 32'h8000_9000, 1'b0, 32'h0,
               mk(EV, 32'h8000_9000, EXC_SYS, 1'b0, 1'b1, 32'h0));
    CP0_We = 1'b0;
    wait_idle();

    // Refetch redirects to its own PC without touching CP0.
    commit_evt(fl("refetch"), 32'h8000_A000, 1'b0, 32'h0,
               mk(32'h8000_A000, 32'h8000_9000, EXC_SYS, 1'b0, 1'b1, 32'h0));
    wait_idle();

    // Stalled commit and all-zero flags do nothing; Cause write lands in ExcCode.
    MEM_Stall = 1'b1;
    drive_commit(fl("ov"), 32'h8000_B000, 1'b0, 32'h0);
    MEM_Stall = 1'b0;
    drive_commit('0, 32'h8000_C000, 1'b0, 32'h0);
    @(negedge clk);
    check("stall_no_flush", {31'd0, Flush}, 32'd0);
    check("stall_epc", EPC_o, 32'h8000_9000);
    cp0_write(CP0_CAUSE, 32'h0000_0030);
    check("mtc0_cause", {27'd0, Cause_ExcCode_o}, {27'd0, EXC_OV});
    cp0_write(5'd9, 32'hFFFF_FFFF);
    check("mtc0_other_ignored", BadVAddr_o, 32'h0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exc_commit_unit.md
Name: exc_commit_unit

Overview:
- Consumes the per-instruction exception vector that the EXE stage produces, including the ALU overflow flag, once the instruction reaches MEM/commit.
- Prioritises all pending causes into one MIPS ExcCode and updates the exception-state registers: EPC, Cause.ExcCode, Cause.BD, Status.EXL, BadVAddr.
- Raises a pipeline flush and issues a redirect PC to IF through a valid/ready handshake.
- Handles ERET and Refetch redirects.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, general exception entry.
- REFILL_VECTOR, 32'hBFC0_0200, TLB refill entry, used when EXL=0.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- MEM_ExceptType  in  ExceptinPipeType  exception flags of the committing instruction
- MEM_Valid  in  1  committing slot holds a real instruction
- MEM_Stall  in  1  MEM stage held this cycle; no commit
- MEM_PC  in  32  PC of the committing instruction
- MEM_IsInDelaySlot  in  1  instruction is in a branch delay slot
- MEM_DataAddr  in  32  load/store effective address
- CP0_We  in  1  MTC0 write strobe
- CP0_Waddr  in  5  8=BadVAddr, 12=Status, 13=Cause, 14=EPC
- CP0_Wdata  in  32  MTC0 data
- Flush  out  1  kill IF..MEM younger instructions
- Redirect_Valid  out  1  Redirect_PC is valid
- Redirect_Ready  in  1  IF accepts the redirect
- Redirect_PC  out  32  new fetch address
- EPC_o  out  32  EPC register
- Cause_ExcCode_o  out  5  Cause.ExcCode
- Cause_BD_o  out  1  Cause.BD
- Status_EXL_o  out  1  Status.EXL
- BadVAddr_o  out  32  BadVAddr register

Behaviour:
- Reset (asynchronous, immediate, any state): FSM=NORMAL; Flush=0, Redirect_Valid=0, Redirect_PC=0; EPC=0, ExcCode=0, BD=0, EXL=0, BadVAddr=0.
- Commit condition: MEM_Valid && !MEM_Stall && state==NORMAL.
- Priority, highest first, with ExcCode:
  - Interrupt 0x00, taken only if EXL=0
  - WrongAddressinIF 0x04; BadVAddr=MEM_PC
  - ReservedInstruction 0x0A
  - Overflow 0x0C
  - Trap 0x0D
  - Syscall 0x08
  - Break 0x09
  - RdWrongAddressinMEM 0x04; BadVAddr=MEM_DataAddr
  - WrWrongAddressinMEM 0x05; BadVAddr=MEM_DataAddr
  - TLB causes (see Optional Feature)
  - Eret
  - Refetch
- Exception taken at commit, registered on the next clock edge:
  - ExcCode updated.
  - If EXL=0 at that moment: EPC = BD ? MEM_PC-4 : MEM_PC; BD = MEM_IsInDelaySlot.
  - If EXL=1: EPC and BD unchanged.
  - EXL set to 1.
  - Redirect_PC = EXC_VECTOR.
  - State -> REDIRECT.
- Eret at commit: EXL cleared; Redirect_PC = EPC (value before this edge); state -> REDIRECT. No other register changes.
- Refetch at commit: Redirect_PC = MEM_PC; no CP0 change; state -> REDIRECT.
- REDIRECT state:
  - Flush=1 and Redirect_Valid=1.
  - All MEM inputs are ignored.
  - On Redirect_Ready=1, state -> NORMAL on the next edge.
  - Minimum flush length is 1 cycle.
- Latency: commit cycle N -> Flush/Redirect_Valid high in cycle N+1.
- Register writes:
  - CP0_We writes EPC, BadVAddr, Status.EXL (bit 1) and Cause.ExcCode (bits 6:2) when no exception/Eret/Refetch commits in the same cycle.
  - The redirect event wins if both occur in the same cycle.
  - Writes to other addresses are ignored.
- Unknown or all-zero flag vector: no action.
- X on MEM_ExceptType is treated as 0.

Optional Feature:
- Macro: EXC_TLB_EN.
- When defined:
  - TLBRefill gives 0x02/0x03 (load/store selected by WrWrongAddressinMEM context bit: store = MEM_DataAddr write path); BadVAddr=MEM_DataAddr; vector = REFILL_VECTOR if EXL=0, else EXC_VECTOR.
  - TLBInvalid gives 0x02/0x03 with EXC_VECTOR.
  - TLBModified gives 0x01 with EXC_VECTOR.
- When undefined: TLB flags are ignored entirely and no TLB logic is synthesised.

Decomposition:
- Shared package/header: ExceptinPipeType (existing), ExcCode localparams (EXC_INT, EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_TR), CP0 register address constants, and the FSM state enum.
- Sub-module exc_prio_encoder: purely combinational. Maps flags + EXL to {take, is_eret, is_refetch, excode, badvaddr_sel, use_refill}.
- The top level holds the FSM and the registers.

Test Plan:
- Overflow, EXL=0, PC=0x8000_1000, not in delay slot -> next cycle ExcCode=0x0C, EPC=0x8000_1000, BD=0, EXL=1, Flush=1, Redirect_PC=0xBFC0_0380.
- Syscall in delay slot, PC=0x8000_2004 -> EPC=0x8000_2000, BD=1, ExcCode=0x08.
- Load address error with Overflow also set, DataAddr=0x8000_0003 -> ExcCode=0x0C (Overflow wins), BadVAddr unchanged. Then load error alone -> ExcCode=0x04, BadVAddr=0x8000_0003.
- Nested: EXL=1, EPC=0x8000_1000, Break at 0x8000_3000 -> EPC stays 0x8000_1000, ExcCode=0x09. Then Eret -> Redirect_PC=0x8000_1000, EXL=0.
- Redirect_Ready held 0 for 3 cycles -> Flush and Redirect_Valid stay high for 4 cycles; an Overflow presented meanwhile is ignored. Assert rst mid-REDIRECT -> all outputs 0 immediately.
- Interrupt with EXL=1 -> no action. Same cycle: MTC0 EPC=0x1234 plus Syscall -> Syscall taken, EPC=MEM_PC.
